// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: one load/store at a time, word-indexed strobes, one-cycle response.
// Optional MEM_ALIGN_CHECK_EN: byte addresses with nonzero [2:0] complete with an error.
module mem_access_ctrl #(
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [63:0]           REQ_ADDR,
  input  logic [63:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [63:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  BUSY,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [DEPTH_LOG2-1:0] MEM_ADDR_OUT,
  output logic [63:0]           WRITE_DATA,
  input  logic [63:0]           DATA_IN,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a request transfers on a posedge where REQ_VALID && REQ_READY; the
  // requester holds REQ_* stable until then. RSP_VALID is a single-cycle pulse with
  // no backpressure.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [DEPTH_LOG2-1:0] r_mem_addr;
  logic [63:0]           r_wdata;
  logic [63:0]           r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_range_err;
  logic                  w_align_err;
  logic                  w_req_err;
  logic                  w_last;
  logic [2:0]            w_unused_lsb;

  assign w_ready     = (r_state == IDLE) && !RESET;
  assign w_accept    = REQ_VALID && w_ready;
  assign w_range_err = |REQ_ADDR[63:DEPTH_LOG2+3];
`ifdef MEM_ALIGN_CHECK_EN
  assign w_align_err = |REQ_ADDR[2:0];
`else
  assign w_align_err = 1'b0;
`endif
  assign w_unused_lsb = REQ_ADDR[2:0];
  assign w_req_err    = w_range_err | w_align_err;
  assign w_last       = (r_cnt == 4'd0);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Strobes are gated by RESET so an abort coinciding with the final store cycle never commits.
  always_comb begin
    w_next    = r_state;
    BUSY      = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    RSP_VALID = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        BUSY      = 1'b1;
        MEM_READ  = !r_write && !RESET;
        MEM_WRITE = r_write && w_last && !RESET;
        if (w_last) w_next = RESP;
      end
      RESP: begin
        BUSY      = 1'b1;
        RSP_VALID = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_mem_addr  <= '0;
      r_wdata     <= 64'd0;
      r_rsp_rdata <= 64'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= REQ_WRITE;
        if (w_req_err) begin
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= 64'd0;
        end else begin
          r_cnt      <= LP_WAIT;
          r_mem_addr <= REQ_ADDR[DEPTH_LOG2+2:3];
          r_wdata    <= REQ_WDATA;
        end
      end
      if (r_state == ACCESS) begin
        if (!w_last) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_rsp_rdata <= r_write ? 64'd0 : DATA_IN;
          r_rsp_err   <= 1'b0;
        end
      end
    end
  end

  assign REQ_READY    = w_ready;
  assign RSP_RDATA    = r_rsp_rdata;
  assign RSP_ERR      = r_rsp_err;
  assign MEM_ADDR_OUT = r_mem_addr;
  assign WRITE_DATA   = r_wdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT_STATES 0/3/2), each with its own memory model.
module tb_mem_access_ctrl;

  localparam int DL2 = 4;
  localparam int N   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   rst, req_valid, req_ready, req_write, rsp_valid, rsp_err, busy, mem_read, mem_write;
  logic [63:0]    req_addr [N];
  logic [63:0]    req_wdata [N];
  logic [63:0]    rsp_rdata [N];
  logic [63:0]    write_data [N];
  logic [63:0]    data_in [N];
  logic [DL2-1:0] mem_addr [N];
  logic [1:0]     dbg_state [N];
  logic           mem_init;

  logic [63:0] mem [N][16];
  logic [63:0] ref_mem [N][16];
  logic [64:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] preload(input int i);
    if (i == 0) return 64'h15;
    if (i == 1) return 64'hC4;
    return 64'(i) * 64'h111;
  endfunction

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_ctrl #(.DEPTH_LOG2(DL2), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
      .CLK(clk), .RESET(rst[g]),
      .REQ_VALID(req_valid[g]), .REQ_READY(req_ready[g]), .REQ_WRITE(req_write[g]),
      .REQ_ADDR(req_addr[g]), .REQ_WDATA(req_wdata[g]),
      .RSP_VALID(rsp_valid[g]), .RSP_RDATA(rsp_rdata[g]), .RSP_ERR(rsp_err[g]),
      .BUSY(busy[g]), .MEM_READ(mem_read[g]), .MEM_WRITE(mem_write[g]),
      .MEM_ADDR_OUT(mem_addr[g]), .WRITE_DATA(write_data[g]), .DATA_IN(data_in[g]),
      .o_dbg_state(dbg_state[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= preload(i);
      end else if (mem_write[k]) begin
        mem[k][mem_addr[k]] <= write_data[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) data_in[k] = mem[k][mem_addr[k]];
  end

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic do_req(input int k, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input string name);
    logic           err;
    logic [63:0]    exp_rd;
    logic [DL2-1:0] idx, prev_idx;
    logic [64:0]    exp;
    logic           done;
    int exp_lat, exp_reads, exp_writes, lat, reads, writes, ready_hi, bad_addr, wait_c;
    idx = addr[DL2+2:3];
    err = (addr[63:3] >= 64'd16);
`ifdef MEM_ALIGN_CHECK_EN
    if (addr[2:0] != 3'd0) err = 1'b1;
`endif
    exp_rd     = (err || wr) ? 64'd0 : ref_mem[k][idx];
    exp_lat    = err ? 1 : ws_of(k) + 2;
    exp_reads  = (err || wr) ? 0 : ws_of(k) + 1;
    exp_writes = (!err && wr) ? 1 : 0;
    if (!err && wr) ref_mem[k][idx] = wdata;
    prev_idx = mem_addr[k];
    wait_c = 0;
    while (!req_ready[k] && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    checks++;
    if (req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: got %b want 1", name, req_ready[k]);
    end
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr; req_wdata[k] = wdata;
    exp_q.push_back({err, exp_rd});
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1; reads = 0; writes = 0; ready_hi = 0; bad_addr = 0; done = 1'b0;
    while (!done && lat <= 40) begin
      if (mem_read[k]) reads++;
      if (mem_write[k]) writes++;
      if ((mem_read[k] || mem_write[k]) && mem_addr[k] !== idx) bad_addr++;
      if (req_ready[k]) ready_hi++;
      if (rsp_valid[k]) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s rsp_timeout: got no RSP_VALID within %0d cycles want 1 pulse", name, lat);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (rsp_err[k] !== exp[64]) begin
        errors++; $display("FAIL %s rsp_err: got %b want %b", name, rsp_err[k], exp[64]);
      end
      checks++;
      if (rsp_rdata[k] !== exp[63:0]) begin
        errors++; $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata[k], exp[63:0]);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (reads != exp_reads || writes != exp_writes) begin
        errors++;
        $display("FAIL %s strobes: got rd=%0d wr=%0d want rd=%0d wr=%0d", name, reads, writes, exp_reads, exp_writes);
      end
      checks++;
      if (bad_addr != 0 || ready_hi != 0) begin
        errors++;
        $display("FAIL %s busy_window: got bad_addr=%0d ready_hi=%0d want 0 0", name, bad_addr, ready_hi);
      end
      if (err) begin
        checks++;
        if (mem_addr[k] !== prev_idx) begin
          errors++; $display("FAIL %s addr_hold: got %h want %h", name, mem_addr[k], prev_idx);
        end
      end
      @(negedge clk);
      checks++;
      if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || rsp_rdata[k] !== exp[63:0]) begin
        errors++;
        $display("FAIL %s after_rsp: got valid=%b ready=%b rdata=%h want 0 1 %h",
                 name, rsp_valid[k], req_ready[k], rsp_rdata[k], exp[63:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = '1; mem_init = 1'b1; req_valid = '0; req_write = '0;
    for (int k = 0; k < N; k++) begin
      req_addr[k] = 64'd0; req_wdata[k] = 64'd0;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = preload(i);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({rsp_valid[k], rsp_err[k], busy[k], mem_read[k], mem_write[k], req_ready[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got v=%b e=%b b=%b rd=%b wr=%b rdy=%b want all 0", k,
                 rsp_valid[k], rsp_err[k], busy[k], mem_read[k], mem_write[k], req_ready[k]);
      end
      checks++;
      if (rsp_rdata[k] !== 64'd0 || write_data[k] !== 64'd0 || mem_addr[k] !== '0 || dbg_state[k] !== 2'd0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got rdata=%h wdata=%h addr=%h st=%0d want 0", k,
                 rsp_rdata[k], write_data[k], mem_addr[k], dbg_state[k]);
      end
    end
    rst = '0; mem_init = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
        errors++; $display("FAIL reset_release[%0d]: got ready=%b busy=%b want 1 0", k, req_ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_load();
    do_req(0, 1'b0, 64'h8, 64'd0, "load_w1");
    checks++;
    if (rsp_rdata[0] !== 64'hC4 || rsp_err[0] !== 1'b0) begin
      errors++; $display("FAIL load_w1_const: got %h/%b want 00000000000000c4/0", rsp_rdata[0], rsp_err[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_req(0, 1'b1, 64'h0, 64'hDEADBEEF, "store_w0");
    do_req(0, 1'b0, 64'h0, 64'd0, "load_w0");
    checks++;
    if (rsp_rdata[0] !== 64'hDEADBEEF) begin
      errors++; $display("FAIL store_load_const: got %h want deadbeef", rsp_rdata[0]);
    end
  endtask

  task automatic test_wait_states();
    do_req(1, 1'b0, 64'h0, 64'd0, "ws3_load_w0");
    checks++;
    if (rsp_rdata[1] !== 64'h15) begin
      errors++; $display("FAIL ws3_const: got %h want 15", rsp_rdata[1]);
    end
    do_req(1, 1'b1, 64'h28, 64'h0123_4567_89AB_CDEF, "ws3_store_w5");
    do_req(1, 1'b0, 64'h28, 64'd0, "ws3_load_w5");
  endtask

  task automatic test_range_err();
    do_req(0, 1'b0, 64'h80, 64'd0, "range_w16");
    checks++;
    if (rsp_err[0] !== 1'b1 || rsp_rdata[0] !== 64'd0) begin
      errors++; $display("FAIL range_const: got %b/%h want 1/0", rsp_err[0], rsp_rdata[0]);
    end
    do_req(0, 1'b1, 64'h8000_0000_0000_0008, 64'h55, "range_store_hi");
    do_req(0, 1'b0, 64'h78, 64'd0, "range_w15_ok");
  endtask

  task automatic test_misalign();
    do_req(0, 1'b0, 64'h0C, 64'd0, "misalign_0c");
    checks++;
`ifdef MEM_ALIGN_CHECK_EN
    if (rsp_err[0] !== 1'b1 || rsp_rdata[0] !== 64'd0) begin
      errors++; $display("FAIL misalign_const: got %b/%h want 1/0", rsp_err[0], rsp_rdata[0]);
    end
`else
    if (rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 64'hC4) begin
      errors++; $display("FAIL misalign_const: got %b/%h want 0/c4", rsp_err[0], rsp_rdata[0]);
    end
`endif
  endtask

  task automatic test_reset_abort();
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 64'h10; req_wdata[2] = 64'hABCD_0123;
    @(negedge clk);
    req_valid[2] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (rsp_valid[2] !== 1'b0) begin
        errors++; $display("FAIL abort_no_rsp c%0d: got %b want 0", c, rsp_valid[2]);
      end
      if (c < 3) @(negedge clk);
    end
    checks++;
    if (mem_write[2] !== 1'b1 || mem_addr[2] !== 4'd2) begin
      errors++; $display("FAIL abort_final_cycle: got wr=%b addr=%h want 1 2", mem_write[2], mem_addr[2]);
    end
    rst[2] = 1'b1;
    #1;
    checks++;
    if (mem_write[2] !== 1'b0) begin
      errors++; $display("FAIL abort_gate: got MEM_WRITE=%b want 0", mem_write[2]);
    end
    @(negedge clk);
    rst[2] = 1'b0;
    #1;
    checks++;
    if (busy[2] !== 1'b0 || req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 64'd0) begin
      errors++;
      $display("FAIL abort_after: got busy=%b ready=%b valid=%b rdata=%h want 0 1 0 0",
               busy[2], req_ready[2], rsp_valid[2], rsp_rdata[2]);
    end
    @(negedge clk);
    do_req(2, 1'b0, 64'h10, 64'd0, "abort_w2_unchanged");
    checks++;
    if (rsp_rdata[2] !== 64'h222) begin
      errors++; $display("FAIL abort_w2_const: got %h want 222", rsp_rdata[2]);
    end
  endtask

  task automatic test_random();
    logic [63:0] addr;
    for (int n = 0; n < 30; n++) begin
      addr = 64'($urandom_range(0, 16'h9F));
      if ($urandom_range(0, 7) == 0) addr[63:40] = 24'($urandom_range(1, 255));
      do_req(0, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, "random");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_wait_states();
    test_range_err();
    test_misalign();
    test_reset_abort();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish within 500000 time units want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the data-memory port. It accepts one load or store request at a time from the MEM pipeline stage over a valid/ready handshake. It converts the 64-bit byte address to a word index, then drives the data memory's read/write strobes, address and write data. It captures the asynchronous read data and returns a one-cycle response with data or an error flag.

Parameters:
DEPTH_LOG2, 4, log2 of data-memory depth in 64-bit words (16 words); also the width of MEM_ADDR_OUT
WAIT_STATES, 0, extra cycles the strobes are held before completion; legal range 0..15

Ports:
CLK  in  1  system clock, all state updates on posedge
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  controller can accept; request taken when REQ_VALID && REQ_READY at posedge
REQ_WRITE  in  1  1 = store, 0 = load
REQ_ADDR  in  64  byte address
REQ_WDATA  in  64  store data
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  64  load data, valid with RSP_VALID
RSP_ERR  out  1  request rejected (out of range / misaligned), valid with RSP_VALID
BUSY  out  1  high whenever state != IDLE
MEM_READ  out  1  data-memory read enable
MEM_WRITE  out  1  data-memory write enable, sampled by memory at posedge
MEM_ADDR_OUT  out  DEPTH_LOG2  data-memory word index
WRITE_DATA  out  64  data-memory write data
DATA_IN  in  64  data-memory asynchronous read data

Behaviour:
- Clocking and reset: one clock (CLK). RESET is synchronous and active-high.
- Reset: state=IDLE, counter=0, latched addr/data/write flag=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDR_OUT=0, WRITE_DATA=0.
- REQ_READY = (state==IDLE) && !RESET.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on accept, latch REQ_WRITE, REQ_ADDR, REQ_WDATA.
  - Word index = REQ_ADDR >> 3.
  - If REQ_ADDR[63:3] >= 2**DEPTH_LOG2: go to RESP with error. No memory strobe is asserted.
  - Otherwise load counter=WAIT_STATES and go to ACCESS.
- ACCESS: MEM_ADDR_OUT = latched word index; WRITE_DATA = latched store data.
  - Load: MEM_READ=1 for every ACCESS cycle.
  - Store: MEM_WRITE=1 only in the final ACCESS cycle (counter==0), so exactly one commit edge. MEM_READ=0 for stores.
  - counter!=0: decrement and stay.
  - counter==0: on load, register DATA_IN into RSP_RDATA; on store, RSP_RDATA<=0. RSP_ERR<=0. Go to RESP.
- RESP: RSP_VALID=1 for exactly this cycle; next state IDLE. There is no response backpressure.
- Outside ACCESS, MEM_READ=MEM_WRITE=0. MEM_ADDR_OUT and WRITE_DATA hold their last values.
- Latency: accept edge to RSP_VALID high = WAIT_STATES+2 cycles. ACCESS lasts WAIT_STATES+1 cycles. Throughput is one request per WAIT_STATES+3 cycles.
- Error response: RSP_ERR=1, RSP_RDATA=0, RESP reached one cycle after accept.
- RSP_RDATA and RSP_ERR hold their value after RESP until the next completion.
- REQ_VALID while BUSY: ignored; the requester must hold it until accepted.
- Reset mid-operation: abort to IDLE on that edge with no response. MEM_WRITE is gated by !RESET, so a store whose final ACCESS cycle coincides with RESET does not commit.
- Store then load to the same address back-to-back returns the stored value, because the write commits before the load's ACCESS begins.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: REQ_ADDR[2:0]!=0 is treated as an error, identical to out-of-range (RSP_ERR=1, no strobe, RESP next cycle). The range check still applies.
- Undefined: REQ_ADDR[2:0] is ignored and the access uses REQ_ADDR>>3.

Test Plan:
- Memory model preloaded word0=0x15, word1=0xC4, WAIT_STATES=0. Load addr 0x8 -> MEM_READ high 1 cycle with MEM_ADDR_OUT=1; RSP_VALID 2 cycles after accept with RSP_RDATA=0xC4, RSP_ERR=0.
- Store 0xDEADBEEF to addr 0x0, then load 0x0 -> exactly one MEM_WRITE cycle with MEM_ADDR_OUT=0; load returns 0xDEADBEEF. REQ_READY is low for the 2 busy cycles in between.
- WAIT_STATES=3, load addr 0x0 -> MEM_READ high 4 consecutive cycles; RSP_VALID 5 cycles after accept; RSP_RDATA=0x15.
- Load addr 0x80 (word 16, out of range) -> no MEM_READ/MEM_WRITE; RSP_VALID next cycle with RSP_ERR=1, RSP_RDATA=0.
- Load addr 0x0C:
  - With MEM_ALIGN_CHECK_EN defined -> RSP_ERR=1, no strobe.
  - With it undefined -> word 1 read, RSP_RDATA=0xC4.
- WAIT_STATES=2 store to addr 0x10; assert RESET on the cycle MEM_WRITE would be high -> no write (word2 unchanged), no RSP_VALID, BUSY=0 and REQ_READY=1 the cycle after RESET drops.
